// File: rtl/spm_bus_pkg.sv
// Shared types and constants for the SPM bus arbiter and its per-port write buffers.
package spm_bus_pkg;

    localparam int SPM_ADDR_W = 14;
    localparam int SPM_EN_W   = 2;
    localparam int SPM_DATA_W = 64;

    typedef struct packed {
        logic [SPM_ADDR_W-1:0] addr;
        logic [SPM_EN_W-1:0]   en;
        logic                  wr;
        logic [SPM_DATA_W-1:0] wdata;
    } spm_req_t;

    // A request is live whenever any enable bit is set.
    function automatic logic req_valid(input spm_req_t req);
        return |req.en;
    endfunction

endpackage

// File: rtl/spm_wr_fifo.sv
// DEPTH-entry request buffer for one write port; holds writes that lost the bus.
module spm_wr_fifo
    import spm_bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  spm_req_t                     din,
    output spm_req_t                     head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    spm_req_t        mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    assign head = mem[rd_ptr];
    assign full = (count == CW'(DEPTH));

    // Storage has no reset: only count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap explicitly so DEPTH=1 keeps both pointers pinned at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/spm_bus_arb.sv
// SPM master bus arbiter: TX port has absolute priority, buffered write ports share the
// remaining slots round-robin. The bus mux is combinational (zero-cycle issue).
module spm_bus_arb
    import spm_bus_pkg::*;
#(
    parameter int ADDR_W = SPM_ADDR_W,
    parameter int EN_W   = SPM_EN_W,
    parameter int DATA_W = SPM_DATA_W,
    parameter int N_WR   = 2,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     tx_spm_addr,
    input  logic [EN_W-1:0]       tx_spm_en,
    input  logic                  tx_spm_wr,
    input  logic [DATA_W-1:0]     tx_spm_wdata,
    input  logic [N_WR*ADDR_W-1:0] wr_spm_addr,
    input  logic [N_WR*EN_W-1:0]  wr_spm_en,
    input  logic [N_WR-1:0]       wr_spm_wr,
    input  logic [N_WR*DATA_W-1:0] wr_spm_wdata,
    output logic [N_WR-1:0]       wr_ready,
    input  logic [DATA_W-1:0]     spm_slv_rdata,
    input  logic                  spm_slv_error,
    output logic [ADDR_W-1:0]     spm_addr,
    output logic [EN_W-1:0]       spm_en,
    output logic                  spm_wr,
    output logic [DATA_W-1:0]     spm_wdata,
    output logic [DATA_W-1:0]     tx_spm_slv_rdata,
    output logic                  tx_spm_slv_error,
    output logic [N_WR-1:0]       overflow_err
);

    localparam int PTR_W = (N_WR > 1) ? $clog2(N_WR) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    spm_req_t           tx_req;
    spm_req_t           bus;
    spm_req_t           in_req   [N_WR];
    spm_req_t           head     [N_WR];
    spm_req_t           cand_req [N_WR];
    logic [CNT_W-1:0]   count    [N_WR];
    logic [N_WR-1:0]    in_vld, buffered, cand, pop, push, direct, full;
    logic [PTR_W-1:0]   rr_ptr, gnt_idx;
    logic               gnt_vld, tx_act;

    assign tx_req = '{addr: tx_spm_addr, en: tx_spm_en, wr: tx_spm_wr, wdata: tx_spm_wdata};
    assign tx_act = req_valid(tx_req);

    // Reads are owned by TX, so response signals pass straight through.
    assign tx_spm_slv_rdata = spm_slv_rdata;
    assign tx_spm_slv_error = spm_slv_error;

    for (genvar g = 0; g < N_WR; g++) begin : g_port
        assign in_req[g] = '{addr:  wr_spm_addr[g*ADDR_W +: ADDR_W],
                             en:    wr_spm_en[g*EN_W +: EN_W],
                             wr:    wr_spm_wr[g],
                             wdata: wr_spm_wdata[g*DATA_W +: DATA_W]};
        assign in_vld[g]   = req_valid(in_req[g]);
        assign buffered[g] = (count[g] != '0);
        // A nonempty buffer hides the incoming request so per-port order holds.
        assign cand[g]     = buffered[g] | in_vld[g];
        assign cand_req[g] = buffered[g] ? head[g] : in_req[g];
        assign pop[g]      = gnt_vld && (gnt_idx == PTR_W'(g)) && buffered[g];
        assign direct[g]   = gnt_vld && (gnt_idx == PTR_W'(g)) && !buffered[g];
        // wr_ready comes from registered count only, so a same-cycle pop cannot admit a push.
        assign push[g]     = in_vld[g] && !direct[g] && wr_ready[g];
        assign wr_ready[g] = ~full[g];

        spm_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (in_req[g]),
            .head  (head[g]),
            .count (count[g]),
            .full  (full[g])
        );
    end

    // Round-robin search starting at rr_ptr; TX activity suppresses every write grant.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (!tx_act) begin
            for (int k = 0; k < N_WR; k++) begin
                idx = (int'(rr_ptr) + k) % N_WR;
                if (!gnt_vld && cand[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'(idx);
                end
            end
        end
    end

    // Zero-latency bus mux: TX, else granted port, else idle.
    always_comb begin
        bus = '0;
        if (tx_act)       bus = tx_req;
        else if (gnt_vld) bus = cand_req[gnt_idx];
    end

    assign spm_addr  = bus.addr;
    assign spm_en    = bus.en;
    assign spm_wr    = bus.wr;
    assign spm_wdata = bus.wdata;

    // Pointer advances past the granted port; sticky overflow on writes to a full buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            overflow_err <= '0;
        end else begin
            if (gnt_vld) rr_ptr <= (gnt_idx == PTR_W'(N_WR - 1)) ? '0 : gnt_idx + 1'b1;
            overflow_err <= overflow_err | (in_vld & ~wr_ready);
        end
    end

endmodule

// File: tb/tb_spm_bus_arb.sv
// Directed bench for spm_bus_arb with N_WR=2, DEPTH=2.
module tb_spm_bus_arb;

    localparam int AW = 14;
    localparam int EW = 2;
    localparam int DW = 64;
    localparam int N  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   tx_spm_addr;
    logic [EW-1:0]   tx_spm_en;
    logic            tx_spm_wr;
    logic [DW-1:0]   tx_spm_wdata;
    logic [N*AW-1:0] wr_spm_addr;
    logic [N*EW-1:0] wr_spm_en;
    logic [N-1:0]    wr_spm_wr;
    logic [N*DW-1:0] wr_spm_wdata;
    logic [N-1:0]    wr_ready;
    logic [DW-1:0]   spm_slv_rdata;
    logic            spm_slv_error;
    logic [AW-1:0]   spm_addr;
    logic [EW-1:0]   spm_en;
    logic            spm_wr;
    logic [DW-1:0]   spm_wdata;
    logic [DW-1:0]   tx_spm_slv_rdata;
    logic            tx_spm_slv_error;
    logic [N-1:0]    overflow_err;

    int errors = 0;
    int checks = 0;

    spm_bus_arb #(.ADDR_W(AW), .EN_W(EW), .DATA_W(DW), .N_WR(N), .DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .tx_spm_addr      (tx_spm_addr),
        .tx_spm_en        (tx_spm_en),
        .tx_spm_wr        (tx_spm_wr),
        .tx_spm_wdata     (tx_spm_wdata),
        .wr_spm_addr      (wr_spm_addr),
        .wr_spm_en        (wr_spm_en),
        .wr_spm_wr        (wr_spm_wr),
        .wr_spm_wdata     (wr_spm_wdata),
        .wr_ready         (wr_ready),
        .spm_slv_rdata    (spm_slv_rdata),
        .spm_slv_error    (spm_slv_error),
        .spm_addr         (spm_addr),
        .spm_en           (spm_en),
        .spm_wr           (spm_wr),
        .spm_wdata        (spm_wdata),
        .tx_spm_slv_rdata (tx_spm_slv_rdata),
        .tx_spm_slv_error (tx_spm_slv_error),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        tx_spm_addr   = '0;
        tx_spm_en     = '0;
        tx_spm_wr     = 1'b0;
        tx_spm_wdata  = '0;
        wr_spm_addr   = '0;
        wr_spm_en     = '0;
        wr_spm_wr     = '0;
        wr_spm_wdata  = '0;
    endtask

    task automatic set_tx(input logic [AW-1:0] a, input logic [EW-1:0] e);
        tx_spm_addr  = a;
        tx_spm_en    = e;
        tx_spm_wr    = 1'b0;
        tx_spm_wdata = 64'h7777_0000_0000_0000;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [EW-1:0] e,
                          input logic [DW-1:0] d);
        wr_spm_addr[p*AW +: AW]  = a;
        wr_spm_en[p*EW +: EW]    = e;
        wr_spm_wr[p]             = 1'b1;
        wr_spm_wdata[p*DW +: DW] = d;
    endtask

    task automatic clr_wr(input int p);
        wr_spm_addr[p*AW +: AW]  = '0;
        wr_spm_en[p*EW +: EW]    = '0;
        wr_spm_wr[p]             = 1'b0;
        wr_spm_wdata[p*DW +: DW] = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        spm_slv_rdata = '0;
        spm_slv_error = 1'b0;
        #2;
        checks++; if (wr_ready !== 2'b11) begin errors++; $display("FAIL reset_wr_ready got=%b exp=11", wr_ready); end
        checks++; if (overflow_err !== 2'b00) begin errors++; $display("FAIL reset_ovf got=%b exp=00", overflow_err); end
        checks++; if (spm_en !== 2'b00) begin errors++; $display("FAIL reset_spm_en got=%b exp=00", spm_en); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_unobstructed();
        set_wr(0, 14'h0010, 2'b01, 64'hAAAA_0000_0000_0010);
        #2;
        checks++; if (spm_addr !== 14'h0010 || spm_en !== 2'b01 || spm_wr !== 1'b1)
            begin errors++; $display("FAIL direct_bus got=%h/%b/%b exp=0010/01/1", spm_addr, spm_en, spm_wr); end
        checks++; if (spm_wdata !== 64'hAAAA_0000_0000_0010)
            begin errors++; $display("FAIL direct_wdata got=%h exp=aaaa000000000010", spm_wdata); end
        tick();
        idle();
        #2;
        checks++; if (spm_en !== 2'b00 || wr_ready !== 2'b11)
            begin errors++; $display("FAIL direct_nobuf got en=%b rdy=%b exp en=00 rdy=11", spm_en, wr_ready); end
        tick();
    endtask

    task automatic test_tx_preempt();
        set_tx(14'h0100, 2'b11);
        set_wr(0, 14'h0020, 2'b01, 64'hBBBB_0000_0000_0020);
        spm_slv_rdata = 64'h1234_5678_9ABC_DEF0;
        spm_slv_error = 1'b1;
        #2;
        checks++; if (spm_addr !== 14'h0100 || spm_en !== 2'b11 || spm_wr !== 1'b0)
            begin errors++; $display("FAIL tx_bus got=%h/%b/%b exp=0100/11/0", spm_addr, spm_en, spm_wr); end
        checks++; if (tx_spm_slv_rdata !== 64'h1234_5678_9ABC_DEF0 || tx_spm_slv_error !== 1'b1)
            begin errors++; $display("FAIL passthru got=%h/%b exp=123456789abcdef0/1", tx_spm_slv_rdata, tx_spm_slv_error); end
        tick();
        idle();
        spm_slv_error = 1'b0;
        #2;
        checks++; if (spm_addr !== 14'h0020 || spm_en !== 2'b01 || spm_wdata !== 64'hBBBB_0000_0000_0020)
            begin errors++; $display("FAIL held_write got=%h/%b/%h exp=0020/01/bbbb000000000020", spm_addr, spm_en, spm_wdata); end
        tick();
        #2;
        checks++; if (spm_en !== 2'b00) begin errors++; $display("FAIL held_drained got en=%b exp=00", spm_en); end
        tick();
    endtask

    task automatic test_overflow();
        set_tx(14'h0200, 2'b11);
        set_wr(0, 14'h0030, 2'b01, 64'h30);
        #2;
        checks++; if (wr_ready !== 2'b11) begin errors++; $display("FAIL ovf_c0_ready got=%b exp=11", wr_ready); end
        tick();
        set_wr(0, 14'h0031, 2'b01, 64'h31);
        #2;
        checks++; if (wr_ready !== 2'b11) begin errors++; $display("FAIL ovf_c1_ready got=%b exp=11", wr_ready); end
        tick();
        set_wr(0, 14'h0032, 2'b01, 64'h32);
        #2;
        checks++; if (wr_ready !== 2'b10 || overflow_err !== 2'b00)
            begin errors++; $display("FAIL ovf_c2 got rdy=%b ovf=%b exp rdy=10 ovf=00", wr_ready, overflow_err); end
        checks++; if (spm_addr !== 14'h0200) begin errors++; $display("FAIL ovf_c2_tx got=%h exp=0200", spm_addr); end
        tick();
        clr_wr(0);
        #2;
        checks++; if (overflow_err !== 2'b01) begin errors++; $display("FAIL ovf_sticky_set got=%b exp=01", overflow_err); end
        tick();
        idle();
        #2;
        checks++; if (spm_addr !== 14'h0030 || spm_en !== 2'b01)
            begin errors++; $display("FAIL ovf_drain0 got=%h/%b exp=0030/01", spm_addr, spm_en); end
        tick();
        #2;
        checks++; if (spm_addr !== 14'h0031 || spm_wdata !== 64'h31 || wr_ready !== 2'b11)
            begin errors++; $display("FAIL ovf_drain1 got=%h/%h rdy=%b exp=0031/31 rdy=11", spm_addr, spm_wdata, wr_ready); end
        tick();
        #2;
        checks++; if (spm_en !== 2'b00 || overflow_err !== 2'b01)
            begin errors++; $display("FAIL ovf_dropped got en=%b ovf=%b exp en=00 ovf=01", spm_en, overflow_err); end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        set_wr(0, 14'h0040, 2'b01, 64'h40);
        set_wr(1, 14'h0050, 2'b10, 64'h50);
        #2;
        checks++; if (spm_addr !== 14'h0040 || spm_en !== 2'b01)
            begin errors++; $display("FAIL rr_first got=%h/%b exp=0040/01", spm_addr, spm_en); end
        tick();
        idle();
        #2;
        checks++; if (spm_addr !== 14'h0050 || spm_en !== 2'b10 || spm_wdata !== 64'h50)
            begin errors++; $display("FAIL rr_second got=%h/%b/%h exp=0050/10/50", spm_addr, spm_en, spm_wdata); end
        tick();
        set_wr(0, 14'h0041, 2'b01, 64'h41);
        set_wr(1, 14'h0051, 2'b10, 64'h51);
        #2;
        checks++; if (spm_addr !== 14'h0041)
            begin errors++; $display("FAIL rr_ptr_wrap got=%h exp=0041", spm_addr); end
        tick();
        idle();
        #2;
        checks++; if (spm_addr !== 14'h0051)
            begin errors++; $display("FAIL rr_ptr_wrap2 got=%h exp=0051", spm_addr); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_addr [4];
        exp_addr[0] = 14'h0060; exp_addr[1] = 14'h0070;
        exp_addr[2] = 14'h0061; exp_addr[3] = 14'h0071;
        do_reset();
        set_tx(14'h0300, 2'b01);
        set_wr(0, 14'h0060, 2'b01, 64'h60);
        set_wr(1, 14'h0070, 2'b10, 64'h70);
        tick();
        set_wr(0, 14'h0061, 2'b01, 64'h61);
        set_wr(1, 14'h0071, 2'b10, 64'h71);
        tick();
        idle();
        #2;
        checks++; if (wr_ready !== 2'b00) begin errors++; $display("FAIL b2b_full got=%b exp=00", wr_ready); end
        for (int i = 0; i < 4; i++) begin
            #0;
            checks++; if (spm_addr !== exp_addr[i] || spm_en === 2'b00)
                begin errors++; $display("FAIL b2b_issue%0d got=%h/%b exp=%h", i, spm_addr, spm_en, exp_addr[i]); end
            tick();
            #2;
        end
        checks++; if (spm_en !== 2'b00) begin errors++; $display("FAIL b2b_empty got en=%b exp=00", spm_en); end
        tick();
    endtask

    task automatic test_async_reset();
        set_tx(14'h0400, 2'b11);
        set_wr(0, 14'h0080, 2'b01, 64'h80);
        tick();
        set_wr(0, 14'h0081, 2'b01, 64'h81);
        tick();
        set_wr(0, 14'h0082, 2'b01, 64'h82);
        tick();
        clr_wr(0);
        #2;
        checks++; if (overflow_err !== 2'b01 || wr_ready !== 2'b10)
            begin errors++; $display("FAIL arst_pre got ovf=%b rdy=%b exp ovf=01 rdy=10", overflow_err, wr_ready); end
        idle();
        reset = 1'b0;
        #1;
        checks++; if (wr_ready !== 2'b11 || overflow_err !== 2'b00 || spm_en !== 2'b00)
            begin errors++; $display("FAIL arst_now got rdy=%b ovf=%b en=%b exp 11/00/00", wr_ready, overflow_err, spm_en); end
        #1;
        reset = 1'b1;
        tick();
        #2;
        checks++; if (spm_en !== 2'b00) begin errors++; $display("FAIL arst_empty got en=%b exp=00", spm_en); end
        set_wr(0, 14'h0090, 2'b01, 64'h90);
        #1;
        checks++; if (spm_addr !== 14'h0090 || spm_en !== 2'b01)
            begin errors++; $display("FAIL arst_after got=%h/%b exp=0090/01", spm_addr, spm_en); end
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        test_reset();
        test_unobstructed();
        test_tx_preempt();
        test_overflow();
        test_round_robin();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
